// File: rtl/pipeline_controller_n_pkg.sv
// Shared constants and types for the N-stage pipeline controller.
package pipeline_controller_n_pkg;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam int unsigned NUM_STAGES_DEF = 6;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned FS_W_DEF       = $clog2(NUM_STAGES_DEF);

  typedef logic [FS_W_DEF-1:0] fs_idx_t;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pipeline_controller_n_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_controller_n.sv
// Stall/flush controller for an N-stage in-order pipeline with deferred flush,
// per-register valid tracking and saturating performance counters.
module pipeline_controller_n
  import pipeline_controller_n_pkg::*;
#(
  parameter int unsigned STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned FS_W  = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              bus_wait,
  input  logic              flush_req,
  input  logic [FS_W-1:0]   flush_stage,
  input  logic              perf_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] valid,
  output logic              flush_pending,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  logic [STAGES-1:0] stall_raw, flush_raw;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              pend_q, pend_d;
  logic [FS_W-1:0]   pend_stage_q, pend_stage_d;
  logic [FS_W-1:0]   fs;
  logic              req_ok, has_fs, older_stall, apply, acc;

  always_comb begin
    // Any stall at stage j propagates down to every younger stage.
    acc = bus_wait;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc          = acc | stall_req[i];
      stall_raw[i] = acc;
    end

    req_ok = flush_req && (flush_stage != '0) && (32'(flush_stage) < STAGES);
    has_fs = req_ok | pend_q;
    if (req_ok && pend_q) begin
      fs = (flush_stage > pend_stage_q) ? flush_stage : pend_stage_q;
    end else if (req_ok) begin
      fs = flush_stage;
    end else begin
      fs = pend_stage_q;
    end

    older_stall = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (i > 32'(fs)) older_stall = older_stall | stall_raw[i];
    end
    apply = has_fs && !older_stall && !bus_wait;

    for (int unsigned i = 0; i < STAGES; i++) begin
      flush_raw[i] = apply && (i >= 1) && (i <= 32'(fs));
    end

    pend_d       = pend_q;
    pend_stage_d = pend_stage_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (has_fs) begin
      pend_d       = 1'b1;
      pend_stage_d = fs;
    end

    // An applicable flush wins over a stall of the same register.
    valid_d    = valid_q;
    valid_d[0] = 1'b1;
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (flush_raw[i]) begin
        valid_d[i] = 1'b0;
      end else if (stall_raw[i]) begin
        valid_d[i] = valid_q[i];
      end else if (stall_raw[i-1]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= STAGES'(1);
      pend_q       <= 1'b0;
      pend_stage_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pend_q       <= pend_d;
      pend_stage_q <= pend_stage_d;
    end
  end

  assign stall         = rst ? '0 : stall_raw;
  assign flush         = rst ? '0 : flush_raw;
  assign valid         = valid_q;
  assign flush_pending = pend_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_raw[0]),
    .clr   (perf_clr),
    .count (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (apply),
    .clr   (perf_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_controller_n.sv
// Directed bench for pipeline_controller_n (STAGES=6, CNT_W=4).
module tb_pipeline_controller_n;
  import pipeline_controller_n_pkg::*;

  localparam int unsigned STAGES = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FS_W   = $clog2(STAGES);

  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stall_req;
  logic              bus_wait;
  logic              flush_req;
  logic [FS_W-1:0]   flush_stage;
  logic              perf_clr;
  logic [STAGES-1:0] stall, flush, valid;
  logic              flush_pending;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  pipeline_controller_n #(
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .bus_wait      (bus_wait),
    .flush_req     (flush_req),
    .flush_stage   (flush_stage),
    .perf_clr      (perf_clr),
    .stall         (stall),
    .flush         (flush),
    .valid         (valid),
    .flush_pending (flush_pending),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1; stall_req = 6'h3f; bus_wait = 1'b1;
    flush_req = 1'b1; flush_stage = 3'd2; perf_clr = 1'b0;
    #3;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_valid", 32'(valid), 32'h01);
    chk("rst_pend", 32'(flush_pending), 32'h0);
    chk("rst_scnt", 32'(stall_cycles), 32'h0);
    chk("rst_fcnt", 32'(flush_count), 32'h0);
    stall_req = '0; bus_wait = 1'b0; flush_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_flush", 32'(flush), 32'h0);

    // 1: fill
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("fill_valid", 32'(valid), (32'h1 << (k + 1)) - 1);
    end

    // 2: single stall at ID
    stall_req = 6'b000100;
    #1 chk("stall_id", 32'(stall), 32'b000111);
    tick();
    stall_req = '0;
    chk("stall_bubble", 32'(valid), 32'b110111);
    chk("stall_cnt1", 32'(stall_cycles), 32'd1);
    idle(3);
    chk("refill1", 32'(valid), 32'h3f);

    // 3: immediate flush of IF..ID
    flush_req = 1'b1; flush_stage = 3'd2;
    #1 chk("flush2", 32'(flush), 32'b000110);
    tick();
    flush_req = 1'b0;
    chk("flush2_valid", 32'(valid), 32'b111001);
    chk("flush2_cnt", 32'(flush_count), 32'd1);
    chk("flush2_pend", 32'(flush_pending), 32'h0);
    idle(5);
    chk("refill2", 32'(valid), 32'h3f);

    // 4: flush deferred behind EX stall
    stall_req = 6'b001000; flush_req = 1'b1; flush_stage = 3'd1;
    #1 chk("def_flush0", 32'(flush), 32'h0);
    chk("def_stall", 32'(stall), 32'b001111);
    tick();
    flush_req = 1'b0;
    chk("def_pend1", 32'(flush_pending), 32'h1);
    chk("def_flush1", 32'(flush), 32'h0);
    tick();
    chk("def_flush2", 32'(flush), 32'h0);
    tick();
    chk("def_pend3", 32'(flush_pending), 32'h1);
    chk("def_valid3", 32'(valid), 32'b001111);
    stall_req = '0;
    #1 chk("def_apply", 32'(flush), 32'b000010);
    tick();
    chk("def_pend_clr", 32'(flush_pending), 32'h0);
    chk("def_valid", 32'(valid), 32'b011101);
    chk("def_scnt", 32'(stall_cycles), 32'd4);
    chk("def_fcnt", 32'(flush_count), 32'd2);
    idle(5);

    // 5: pending stage upgraded by a younger-killing request
    stall_req = 6'b010000; flush_req = 1'b1; flush_stage = 3'd1;
    tick();
    flush_stage = 3'd3;
    #1 chk("merge_flush0", 32'(flush), 32'h0);
    tick();
    flush_req = 1'b0;
    chk("merge_pend", 32'(flush_pending), 32'h1);
    stall_req = '0;
    #1 chk("merge_apply", 32'(flush), 32'b001110);
    tick();
    chk("merge_pend_clr", 32'(flush_pending), 32'h0);
    chk("merge_valid", 32'(valid), 32'b110001);
    chk("merge_fcnt", 32'(flush_count), 32'd3);
    chk("merge_scnt", 32'(stall_cycles), 32'd6);

    // bus_wait freezes everything
    bus_wait = 1'b1;
    #1 chk("bw_stall", 32'(stall), 32'h3f);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bw_valid", 32'(valid), 32'b110001);
    end
    bus_wait = 1'b0;
    chk("bw_scnt", 32'(stall_cycles), 32'd9);

    // out-of-range flush stages are ignored
    flush_req = 1'b1; flush_stage = 3'd0;
    #1 chk("oor0_flush", 32'(flush), 32'h0);
    tick();
    chk("oor0_pend", 32'(flush_pending), 32'h0);
    flush_stage = 3'd6;
    #1 chk("oor6_flush", 32'(flush), 32'h0);
    tick();
    chk("oor6_pend", 32'(flush_pending), 32'h0);

    // flush of oldest stage applies even when WB itself stalls
    flush_stage = STG_WB[FS_W-1:0]; stall_req = 6'b100000;
    #1 chk("wb_flush", 32'(flush), 32'b111110);
    chk("wb_stall", 32'(stall), 32'h3f);
    tick();
    flush_req = 1'b0;
    chk("wb_valid", 32'(valid), 32'h01);
    chk("wb_fcnt", 32'(flush_count), 32'd4);
    chk("wb_scnt", 32'(stall_cycles), 32'd10);

    // 6: counter saturation and clear priority
    stall_req = 6'b000001;
    idle(20);
    chk("sat_scnt", 32'(stall_cycles), 32'd15);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("clr_scnt", 32'(stall_cycles), 32'd0);
    chk("clr_fcnt", 32'(flush_count), 32'd0);

    // async reset while a flush is pending
    stall_req = 6'b001000; flush_req = 1'b1; flush_stage = 3'd1;
    tick();
    flush_req = 1'b0;
    idle(2);
    chk("pre_rst_pend", 32'(flush_pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pend", 32'(flush_pending), 32'h0);
    chk("arst_valid", 32'(valid), 32'h01);
    chk("arst_stall", 32'(stall), 32'h0);
    stall_req = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(valid), 32'b000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
